// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width, default bit period.
// Latency: none (declarations only). Backpressure: not applicable.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 434;   // 50 MHz / 115200, shared with the transmitter

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for an idle-high serial input; flops reset to 1.
// Latency: SYNC_STAGES cycles. Backpressure: none.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined); mid-bit sampling, 1-cycle valid/frame_err strobes.
// Latency: strobe one cycle after the stop-bit sample. Backpressure: none, the consumer must take each strobe.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_in,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_W - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (uart_in),
        .dout (rx_s)
    );

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   stop_ok;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;

    assign stop_ok = rx_s && !par_err_q;
`else
    assign stop_ok = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the start bit at its centre; this fixes mid-bit alignment for the frame.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ^{shreg_q, rx_s};
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (stop_ok) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low (break) line must not be mistaken for a new start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frame-timeline model checked every cycle plus literal byte/strobe expectations.
// Covers UART_RX_PARITY_EN when that macro is defined.
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int H    = CPB / 2;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_BIT = 9;
`else
    localparam int STOP_BIT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_in = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_in   (uart_in),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the line as the receiver sees it is uart_in delayed SYNC cycles; a frame
    // begins at the first low sample while idle and every later decision happens at a
    // fixed offset from that edge (start check at H, bit i at H+(i+1)*CPB).
    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_WAIT  = 2;

    logic [SYNC-1:0] dly;
    int              n;
    int              m_mode;
    int              m_t0;
    logic [7:0]      m_bits;
    logic            m_par;
    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_ferr;
    logic            m_busy;
    logic            r;
    int              off;
    int              bitno;

    assign r     = dly[SYNC-1];
    assign off   = n - m_t0;
    assign bitno = (off - H) / CPB - 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly     <= '1;
            n       <= 0;
            m_mode  <= M_IDLE;
            m_t0    <= 0;
            m_bits  <= '0;
            m_par   <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            n       <= n + 1;
            dly     <= {dly[SYNC-2:0], uart_in};
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (!r) begin
                        m_mode <= M_FRAME;
                        m_t0   <= n;
                        m_busy <= 1'b1;
                    end
                end
                M_FRAME: begin
                    if (off == H) begin
                        if (r) begin
                            m_mode <= M_IDLE;
                            m_busy <= 1'b0;
                        end
                    end else if (off > H && ((off - H) % CPB) == 0) begin
                        if (bitno < 8) begin
                            m_bits[bitno] <= r;
                        end else if (bitno < STOP_BIT) begin
                            m_par <= r;
                        end else if (r && (STOP_BIT == 8 || ((^m_bits) ^ m_par) == 1'b0)) begin
                            m_data  <= m_bits;
                            m_valid <= 1'b1;
                            m_mode  <= M_IDLE;
                            m_busy  <= 1'b0;
                        end else begin
                            m_ferr <= 1'b1;
                            m_mode <= M_WAIT;
                        end
                    end
                end
                default: begin
                    if (r) begin
                        m_mode <= M_IDLE;
                        m_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic       chk_en = 1'b0;
    logic [7:0] rx_q[$];
    int         ferr_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", valid, m_valid);
            chk("frame_err", frame_err, m_ferr);
            chk("data", data, m_data);
            chk("busy", busy, m_busy);
            chk("strobe_excl", valid & frame_err, 0);
            if (valid) rx_q.push_back(data);
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic idle(input int cycles);
        uart_in = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int cycles);
        uart_in = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip, CPB);
`endif
        drive_bit(stop_val, CPB);
    endtask

    task automatic chk_rx(input string name, input int i, input logic [7:0] exp);
        chk(name, (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF, {24'd0, exp});
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        send_frame(8'h61, 1'b0, 1'b1);
        idle(2 * CPB);
        chk("a_count", rx_q.size(), 1);
        chk_rx("a_byte", 0, 8'h61);
        chk("a_model", m_data, 8'h61);
        chk("a_busy", busy, 0);

        send_frame(8'h7a, 1'b0, 1'b1);
        send_frame(8'h78, 1'b0, 1'b1);
        send_frame(8'h63, 1'b0, 1'b1);
        send_frame(8'h76, 1'b0, 1'b1);
        idle(2 * CPB);
        chk("b2b_count", rx_q.size(), 5);
        chk_rx("b2b_z", 1, 8'h7a);
        chk_rx("b2b_x", 2, 8'h78);
        chk_rx("b2b_c", 3, 8'h63);
        chk_rx("b2b_v", 4, 8'h76);

        drive_bit(1'b0, 5);
        idle(2 * CPB);
        chk("glitch_count", rx_q.size(), 5);
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_busy", busy, 0);

        send_frame(8'h55, 1'b0, 1'b0);
        drive_bit(1'b0, 100);
        chk("brk_ferr", ferr_cnt, 1);
        chk("brk_busy", busy, 1);
        chk("brk_data", data, 8'h76);
        idle(2 * CPB);
        chk("brk_idle", busy, 0);
        send_frame(8'h73, 1'b0, 1'b1);
        idle(2 * CPB);
        chk("s_count", rx_q.size(), 6);
        chk_rx("s_byte", 5, 8'h73);

        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
        drive_bit(1'b0, H);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        @(posedge clk);
        #1 uart_in = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2 * CPB);
        chk("rst_count", rx_q.size(), 6);
        send_frame(8'h66, 1'b0, 1'b1);
        idle(2 * CPB);
        chk("f_count", rx_q.size(), 7);
        chk_rx("f_byte", 6, 8'h66);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h64, 1'b0, 1'b1);
        idle(2 * CPB);
        chk("par_ok_count", rx_q.size(), 8);
        chk_rx("par_ok_byte", 7, 8'h64);
        send_frame(8'h64, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("par_bad_count", rx_q.size(), 8);
        chk("par_bad_ferr", ferr_cnt, 2);
        chk("par_bad_data", data, 8'h64);
`endif

        chk("final_ferr_min", (ferr_cnt >= 1) ? 1 : 0, 1);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
